// File: rtl/mx11_regbank.sv
// MX11 register bank: DEPTH registers driven to the SEU as reg_line, SEU write-back on wb_en,
// and an external load port with a one-entry holding buffer that always yields to write-back.
module mx11_regbank #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FLAG_IDX   = 7,
    parameter int STARVE_LIM = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DEPTH*DATA_WIDTH-1:0]   data_line,
    input  logic [7:0]                    load_addr,
    input  logic                          wb_en,
    input  logic                          ext_valid,
    output logic                          ext_ready,
    input  logic [3:0]                    ext_addr,
    input  logic [DATA_WIDTH-1:0]         ext_data,
    output logic [DEPTH*DATA_WIDTH-1:0]   reg_line,
    output logic                          ext_starve,
    output logic                          wb_err
);

    localparam int AGE_W = $clog2(STARVE_LIM + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIM);

    // Handshake: an external load transfers on a rising edge where ext_valid and ext_ready
    // are both high. ext_ready drops only while the buffer is full and write-back holds the bank.
    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] lanes  [DEPTH];

    logic                  pend_valid_q, pend_valid_d;
    logic [3:0]            pend_addr_q,  pend_addr_d;
    logic [DATA_WIDTH-1:0] pend_data_q,  pend_data_d;
    logic [AGE_W-1:0]      age_q,        age_d;
    logic                  ext_starve_q, ext_starve_d;
    logic                  wb_err_q,     wb_err_d;

    logic [3:0] wb_mode;
    logic [3:0] wb_dst;
    logic       commit;
    logic       accept;

    assign wb_mode   = load_addr[7:4];
    assign wb_dst    = load_addr[3:0];
    assign ext_ready = ~pend_valid_q | ~wb_en;
    assign commit    = pend_valid_q & ~wb_en;
    assign accept    = ext_valid & ext_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lanes[i]                                 = data_line[i*DATA_WIDTH +: DATA_WIDTH];
            reg_line[i*DATA_WIDTH +: DATA_WIDTH]     = regs_q[i];
        end
    end

    // Write-back and the buffered external commit are mutually exclusive by construction:
    // the buffer only drains on edges where wb_en is low.
    always_comb begin
        regs_d   = regs_q;
        wb_err_d = wb_err_q;
        if (wb_en) begin
            if (wb_mode == 4'h0) begin
                regs_d[wb_dst]   = lanes[wb_dst];
                regs_d[FLAG_IDX] = lanes[FLAG_IDX];
            end else if (wb_mode == 4'h1) begin
                regs_d[FLAG_IDX] = lanes[FLAG_IDX];
            end else begin
                wb_err_d = 1'b1;
            end
        end else if (pend_valid_q) begin
            regs_d[pend_addr_q] = pend_data_q;
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        if (commit) begin
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = ext_addr;
            pend_data_d  = ext_data;
        end
    end

    // age counts edges on which a buffered write was held off by write-back.
    always_comb begin
        age_d        = age_q;
        ext_starve_d = ext_starve_q;
        if (commit) begin
            age_d = '0;
        end else if (pend_valid_q && wb_en && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end
        if (age_d == AGE_MAX) begin
            ext_starve_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            age_q        <= '0;
            ext_starve_q <= 1'b0;
            wb_err_q     <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            age_q        <= age_d;
            ext_starve_q <= ext_starve_d;
            wb_err_q     <= wb_err_d;
        end
    end

    assign ext_starve = ext_starve_q;
    assign wb_err     = wb_err_q;

endmodule
